// File: rtl/spi_sram_arbiter_if.sv
// Bundles the two requester ports, the shared read data and the SPI SRAM pins.
// The arbiter uses the slave view; a requester/pin-level model uses the master view.
interface spi_sram_arbiter_if;
    // CPU data-memory requester
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;

    // Debug load/dump requester
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_ack;

    // Shared status and read data
    logic [7:0]  rdata;
    logic        busy;

    // External SPI SRAM pins
    logic        sram_cs;
    logic        sram_sclk;
    logic        sram_mosi;
    logic        sram_miso;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  sram_miso,
        output cpu_ack, dbg_ack, rdata, busy,
        output sram_cs, sram_sclk, sram_mosi
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output sram_miso,
        input  cpu_ack, dbg_ack, rdata, busy,
        input  sram_cs, sram_sclk, sram_mosi
    );
endinterface

// File: rtl/spi_sram_arbiter.sv
// Shares one SPI SRAM between the CPU and debug requesters. Each grant runs a
// full mode-0 byte transaction: {command, 16-bit address, data}, MSB first,
// SCK = clk/2, MISO sampled on the clk edge that ends each SCK-high cycle.
module spi_sram_arbiter #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic               clk,
    input  logic               reset,
    spi_sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] shift;      // outgoing frame / incoming MISO bits
    logic [4:0]  bit_cnt;    // bit being transferred, 0..31
    logic        phase;      // 0 = SCK low half, 1 = SCK high half
    logic        grant_dbg;  // current transaction belongs to the debug port
    logic        grant_we;   // current transaction is a write
    logic        last_dbg;   // debug port won the previous grant

    logic        pick_dbg;
    logic        pick_we;
    logic [15:0] pick_addr;
    logic [7:0]  pick_wdata;
    logic [31:0] load_word;

    // Round-robin choice between requesters and the frame to load on grant
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pick_dbg   = 1'b0;
        pick_we    = bus.cpu_we;
        pick_addr  = bus.cpu_addr;
        pick_wdata = bus.cpu_wdata;
        // On a tie, the port that did not win last time goes next.
        if (bus.dbg_req && (!bus.cpu_req || !last_dbg)) begin
            pick_dbg   = 1'b1;
            pick_we    = bus.dbg_we;
            pick_addr  = bus.dbg_addr;
            pick_wdata = bus.dbg_wdata;
        end
        load_word = {pick_we ? CMD_WRITE : CMD_READ, pick_addr,
                     pick_we ? pick_wdata : 8'h00};
    end

    // Transaction FSM with all pin and handshake outputs registered
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 5'd0;
            phase         <= 1'b0;
            grant_dbg     <= 1'b0;
            grant_we      <= 1'b0;
            last_dbg      <= 1'b1;  // makes the CPU win the first tie
            bus.cpu_ack   <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.rdata     <= 8'h00;
            bus.busy      <= 1'b0;
            bus.sram_cs   <= 1'b1;
            bus.sram_sclk <= 1'b0;
            bus.sram_mosi <= 1'b0;
            // NOTE: the shift register is deliberately not reset; it is always
            // loaded at grant before any bit of it is used.
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sram_cs   <= 1'b1;
                    bus.sram_sclk <= 1'b0;
                    if (bus.cpu_req || bus.dbg_req) begin
                        grant_dbg     <= pick_dbg;
                        grant_we      <= pick_we;
                        last_dbg      <= pick_dbg;
                        shift         <= load_word;
                        bus.sram_cs   <= 1'b0;
                        bus.sram_mosi <= load_word[31];
                        bus.busy      <= 1'b1;
                        state         <= SELECT;
                    end
                end
                SELECT: begin
                    bus.sram_sclk <= 1'b0;
                    bus.sram_mosi <= shift[31];
                    bit_cnt       <= 5'd0;
                    phase         <= 1'b0;
                    state         <= SHIFT;
                end
                SHIFT: begin
                    if (!phase) begin
                        // Rising SCK: the SRAM samples the MOSI bit already on the pin.
                        bus.sram_sclk <= 1'b1;
                        phase         <= 1'b1;
                    end else begin
                        // End of SCK high: capture MISO, present the next MOSI bit.
                        shift         <= {shift[30:0], bus.sram_miso};
                        bus.sram_sclk <= 1'b0;
                        phase         <= 1'b0;
                        if (bit_cnt == 5'd31) begin
                            bus.sram_cs   <= 1'b1;
                            bus.sram_mosi <= 1'b0;
                            if (!grant_we) begin
                                bus.rdata <= {shift[6:0], bus.sram_miso};
                            end
                            bus.cpu_ack <= !grant_dbg;
                            bus.dbg_ack <= grant_dbg;
                            state       <= DONE;
                        end else begin
                            bus.sram_mosi <= shift[30];
                            bit_cnt       <= bit_cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Bench for spi_sram_arbiter: directed requester stimulus pushes expected
// transactions into a scoreboard; a pin-level SPI SRAM model/monitor decodes
// each chip-select window and compares it against the queue head.
module tb_spi_sram_arbiter;

    logic clk = 1'b0;
    logic reset;

    spi_sram_arbiter_if bus ();

    spi_sram_arbiter #(
        .CMD_READ  (8'h03),
        .CMD_WRITE (8'h02)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dbg;
        logic [31:0] word;
        logic [7:0]  rdata;
        int          gap;   // required cs-high cycles before this txn, 0 = unchecked
    } exp_t;

    exp_t sb[$];

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int ack_seen  = 0;
    int exp_acks  = 0;
    bit abort_pending = 1'b0;

    logic [7:0] mem [logic [15:0]];
    logic       miso_q = 1'b0;
    assign bus.sram_miso = miso_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SPI SRAM model and monitor, sampling pins on the falling clk edge
    bit          active    = 1'b0;
    logic [31:0] cap       = 32'h0;
    int          nrise     = 0;
    int          low_cnt   = 0;
    int          sel_cyc   = 0;
    int          hi_cnt    = 1000;
    int          gap_seen  = 0;
    logic        prev_sclk = 1'b0;
    logic [7:0]  rd_byte   = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.cpu_ack === 1'b1 || bus.dbg_ack === 1'b1) ack_seen++;
        if (!active) begin
            if (bus.sram_cs === 1'b0) begin
                active   = 1'b1;
                cap      = 32'h0;
                nrise    = 0;
                low_cnt  = 1;
                sel_cyc  = cyc;
                gap_seen = hi_cnt;
                hi_cnt   = 0;
            end else begin
                hi_cnt++;
            end
        end else if (bus.sram_cs === 1'b0) begin
            low_cnt++;
            if (bus.sram_sclk === 1'b1 && prev_sclk === 1'b0) begin
                cap = {cap[30:0], bus.sram_mosi};
                nrise++;
                if (nrise == 24) rd_byte = mem.exists(cap[15:0]) ? mem[cap[15:0]] : 8'h00;
                if (nrise >= 25 && nrise <= 32) miso_q = rd_byte[32-nrise];
            end
        end else begin
            active = 1'b0;
            hi_cnt = 1;
            if (abort_pending) begin
                abort_pending = 1'b0;
                check("abort_sclk", bus.sram_sclk, 1'b0);
                check("abort_busy", bus.busy, 1'b0);
                check("abort_no_ack", bus.cpu_ack | bus.dbg_ack, 1'b0);
            end else begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("mosi_word", cap, e.word);
                    check("cs_low_cycles", low_cnt, 65);
                    check("sclk_rises", nrise, 32);
                    check("ack_latency", cyc - sel_cyc, 65);
                    check("cpu_ack", bus.cpu_ack, !e.dbg);
                    check("dbg_ack", bus.dbg_ack, e.dbg);
                    check("rdata", bus.rdata, e.rdata);
                    if (e.gap != 0) check("cs_high_gap", gap_seen, e.gap);
                end
                if (cap[31:24] == 8'h02) mem[cap[23:8]] = cap[7:0];
            end
        end
        prev_sclk = bus.sram_sclk;
    end

    // One request on one port; waits (bounded) for its ack, then drops req
    task automatic run_txn(input bit dbg, input bit we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd,
                           input int gap, input int change_at);
        exp_t e;
        int   n;
        bit   got;
        e.dbg   = dbg;
        e.word  = {we ? 8'h02 : 8'h03, addr, we ? wd : 8'h00};
        e.rdata = exp_rd;
        e.gap   = gap;
        sb.push_back(e);
        exp_acks++;
        if (dbg) begin
            bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd; bus.dbg_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (change_at > 0 && n == change_at) bus.cpu_addr = 16'hFFFF;
            got = dbg ? bus.dbg_ack : bus.cpu_ack;
        end
        check(dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", got, 1'b1);
        if (dbg) bus.dbg_req = 1'b0;
        else     bus.cpu_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  acks;
        int  last_ack;
        exp_t e;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0; bus.dbg_wdata = 8'h0;
        mem[16'h00FF] = 8'h5A;
        mem[16'h1000] = 8'h77;
        mem[16'hFFFF] = 8'hEE;
        mem[16'h0001] = 8'h3C;
        mem[16'h4000] = 8'h99;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs", bus.sram_cs, 1'b1);
        check("rst_sclk", bus.sram_sclk, 1'b0);
        check("rst_mosi", bus.sram_mosi, 1'b0);
        check("rst_cpu_ack", bus.cpu_ack, 1'b0);
        check("rst_dbg_ack", bus.dbg_ack, 1'b0);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // CPU write, debug read, then a write that must not touch rdata
        run_txn(1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        run_txn(1'b1, 1'b0, 16'h00FF, 8'h00, 8'h5A, 0, 0);
        repeat (3) @(negedge clk);
        run_txn(1'b0, 1'b1, 16'h0055, 8'h33, 8'h5A, 0, 0);
        repeat (3) @(negedge clk);

        // Reset restores rdata and the CPU-first tie-break
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_rdata", bus.rdata, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests held high: CPU, DBG, CPU, DBG
        for (int i = 0; i < 4; i++) begin
            e.dbg   = (i % 2 == 1);
            e.word  = (i % 2 == 1) ? 32'h02_3000_22 : 32'h02_2000_11;
            e.rdata = 8'h00;
            e.gap   = (i == 0) ? 0 : 2;
            sb.push_back(e);
        end
        exp_acks += 4;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2000; bus.cpu_wdata = 8'h11;
        bus.dbg_we = 1'b1; bus.dbg_addr = 16'h3000; bus.dbg_wdata = 8'h22;
        bus.cpu_req = 1'b1;
        bus.dbg_req = 1'b1;
        acks = 0; n = 0; last_ack = -1;
        while (acks < 4 && n < 600) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack || bus.dbg_ack) begin
                acks++;
                if (last_ack >= 0) check("ack_spacing", n - last_ack, 67);
                last_ack = n;
            end
        end
        check("tie_acks", acks, 4);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        repeat (3) @(negedge clk);

        // Address changed mid-transaction is ignored
        run_txn(1'b0, 1'b0, 16'h1000, 8'h00, 8'h77, 0, 10);
        repeat (3) @(negedge clk);

        // Reset during a read aborts it cleanly without an ack
        abort_pending = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4000; bus.cpu_req = 1'b1;
        n = 0;
        while (!bus.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_granted", bus.busy, 1'b1);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_seen", abort_pending, 1'b0);

        // Normal read after the abort
        run_txn(1'b0, 1'b0, 16'h0001, 8'h00, 8'h3C, 0, 0);
        repeat (3) @(negedge clk);

        // Debug request arriving during a CPU transaction follows it
        fork
            run_txn(1'b0, 1'b1, 16'h2222, 8'h44, 8'h3C, 0, 0);
            begin
                repeat (30) @(negedge clk);
                run_txn(1'b1, 1'b0, 16'h00FF, 8'h00, 8'h5A, 2, 0);
            end
        join
        repeat (5) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        check("ack_count", ack_seen, exp_acks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
